// File: rtl/ip_hdr_sched.sv
// ip_hdr_sched: arbitrates cfg and two tx channels onto a single IP header builder and locks its buffer to the tx owner.
module ip_hdr_sched #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cfg_valid,
  input  logic        i_cfg_sel,
  input  logic [31:0] i_cfg_ip,
  output logic        o_cfg_ack,
  output logic        o_cfg_done,
  input  logic        i_tx0_req,
  input  logic [15:0] i_tx0_len,
  output logic        o_tx0_ack,
  output logic        o_tx0_done,
  input  logic        i_tx0_release,
  input  logic        i_tx1_req,
  input  logic [15:0] i_tx1_len,
  output logic        o_tx1_ack,
  output logic        o_tx1_done,
  input  logic        i_tx1_release,
  output logic        o_err,
  output logic        o_hb_trig,
  output logic        o_hb_set_local,
  output logic        o_hb_set_dest,
  output logic [15:0] o_hb_len,
  output logic [7:0]  o_hb_ip0,
  output logic [7:0]  o_hb_ip1,
  output logic [7:0]  o_hb_ip2,
  output logic [7:0]  o_hb_ip3,
  input  logic        i_hb_ready,
  output logic        o_busy,
  output logic [1:0]  o_owner
);
  typedef enum logic [2:0] {IDLE, STROBE, WAIT, HOLD, GAP} state_t;
  state_t state, state_n;
  logic [7:0] timer, timer_n;
  logic rr, rr_n, sel, sel_n;
  logic [31:0] ip_q, ip_n;
  logic [15:0] len_n;
  logic [1:0] owner_n;
  logic cfg_ack_n, cfg_done_n, tx0_ack_n, tx0_done_n, tx1_ack_n, tx1_done_n;
  logic err_n, trig_n, set_local_n, set_dest_n, busy_n;
  logic tx_pick, timeout;
  // rr = 1 gives tx1 the tie; it flips to the other channel after a successful build
  assign tx_pick = i_tx1_req && (!i_tx0_req || rr);
  assign timeout = timer == 8'(TIMEOUT_CYCLES - 1);
  assign {o_hb_ip0, o_hb_ip1, o_hb_ip2, o_hb_ip3} = ip_q;
  always_comb begin
    state_n = state;
    timer_n = timer;
    rr_n = rr;
    sel_n = sel;
    ip_n = ip_q;
    len_n = o_hb_len;
    owner_n = o_owner;
    {cfg_ack_n, cfg_done_n, tx0_ack_n, tx0_done_n, tx1_ack_n, tx1_done_n} = '0;
    {err_n, trig_n, set_local_n, set_dest_n} = '0;
    case (state)
      IDLE: begin
        if (i_cfg_valid) begin
          owner_n = 2'd1;
          sel_n = i_cfg_sel;
          ip_n = i_cfg_ip;
          state_n = STROBE;
        end else if (i_tx0_req || i_tx1_req) begin
          owner_n = tx_pick ? 2'd3 : 2'd2;
          len_n = tx_pick ? i_tx1_len : i_tx0_len;
          state_n = STROBE;
        end
      end
      STROBE: begin
        trig_n = o_owner[1];
        set_local_n = o_owner == 2'd1 && !sel;
        set_dest_n = o_owner == 2'd1 && sel;
        cfg_ack_n = o_owner == 2'd1;
        tx0_ack_n = o_owner == 2'd2;
        tx1_ack_n = o_owner == 2'd3;
        timer_n = '0;
        state_n = WAIT;
      end
      WAIT: begin
        if (i_hb_ready || timeout) begin
          cfg_done_n = o_owner == 2'd1;
          tx0_done_n = o_owner == 2'd2;
          tx1_done_n = o_owner == 2'd3;
          err_n = !i_hb_ready;
          if (i_hb_ready && o_owner[1]) begin
            state_n = HOLD;
            rr_n = o_owner == 2'd2;
          end else begin
            state_n = GAP;
            owner_n = '0;
          end
        end else timer_n = timer + 8'd1;
      end
      HOLD: begin
        if ((o_owner == 2'd2 && i_tx0_release) || (o_owner == 2'd3 && i_tx1_release)) begin
          state_n = GAP;
          owner_n = '0;
        end
      end
      GAP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    busy_n = state_n != IDLE;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      timer <= '0;
      rr <= 1'b0;
      sel <= 1'b0;
      ip_q <= '0;
      o_hb_len <= '0;
      o_owner <= '0;
      o_busy <= 1'b0;
      {o_cfg_ack, o_cfg_done, o_tx0_ack, o_tx0_done, o_tx1_ack, o_tx1_done} <= '0;
      {o_err, o_hb_trig, o_hb_set_local, o_hb_set_dest} <= '0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      rr <= rr_n;
      sel <= sel_n;
      ip_q <= ip_n;
      o_hb_len <= len_n;
      o_owner <= owner_n;
      o_busy <= busy_n;
      {o_cfg_ack, o_cfg_done, o_tx0_ack, o_tx0_done, o_tx1_ack, o_tx1_done} <=
        {cfg_ack_n, cfg_done_n, tx0_ack_n, tx0_done_n, tx1_ack_n, tx1_done_n};
      {o_err, o_hb_trig, o_hb_set_local, o_hb_set_dest} <= {err_n, trig_n, set_local_n, set_dest_n};
    end
  end
endmodule
